// File: rtl/bundle_pair_pkg.sv
// Shared types for the operand pair packer: FSM state and the default bundle layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bundle_pair_pkg;

  localparam int W_DEFAULT = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_e;

  typedef struct packed {
    logic [W_DEFAULT-1:0] in1;
    logic [W_DEFAULT-1:0] in2;
  } pair_t;

endpackage

// File: rtl/bundle_pair_packer_if.sv
// Operand-beat input and bundle output handshake bundle for the pair packer.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carried as plain valid/ready signals.
interface bundle_pair_packer_if #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_in1;
  logic [W-1:0]  out_in2;
  logic [CW-1:0] count;

  // Operand source and bundle consumer side.
  modport master (
    output in_valid, in_data, clear, out_ready,
    input  in_ready, out_valid, out_in1, out_in2, count
  );

  // Packer side.
  modport slave (
    input  in_valid, in_data, clear, out_ready,
    output in_ready, out_valid, out_in1, out_in2, count
  );
endinterface

// File: rtl/bundle_pair_fifo.sv
// Circular bundle buffer: storage, read/write pointers and occupancy count.
// Latency: a push is visible at the head one cycle later when the buffer was empty.
// Backpressure: caller must not push when full nor pop when empty; push and pop may coincide.
module bundle_pair_fifo
  import bundle_pair_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = pair_t
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  T                           push_dat_i,
  input  logic                       pop_i,
  output T                           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Explicit wrap keeps DEPTH=1 correct where a 1-bit pointer would not wrap to zero.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Next pointer and occupancy values from the push/pop strobes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; cleared asynchronously so nothing survives a reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Bundle storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bundle_pair_packer.sv
// Packs consecutive operand beats into {in1, in2} bundles and queues them for a consumer.
// Latency: bundle at the FIFO head the cycle after its second beat is accepted.
// Backpressure: first beat always taken; second beat waits for a free FIFO slot; clear blocks input.
module bundle_pair_packer
  import bundle_pair_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = 2
) (
  input logic                 clock,
  input logic                 reset,
  bundle_pair_packer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [W-1:0] in1;
    logic [W-1:0] in2;
  } pair_w_t;

  state_e        state_q, state_d;
  logic [W-1:0]  hold_q, hold_d;
  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  pair_w_t       push_dat;
  pair_w_t       head;
  logic [CW-1:0] fifo_count;

  // in_ready depends only on registered state plus reset/clear, never on out_ready.
  assign full         = (fifo_count == CW'(DEPTH));
  assign bus.in_ready = !reset && !bus.clear && ((state_q == EMPTY) || !full);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (fifo_count != '0);
  assign pop          = bus.out_valid && bus.out_ready;
  assign push_dat     = '{in1: hold_q, in2: bus.in_data};

  // Pair assembly: hold the first beat, emit a bundle on the second; clear drops a held beat.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    push    = 1'b0;
    if (bus.clear) begin
      state_d = EMPTY;
    end else if (accept) begin
      if (state_q == EMPTY) begin
        hold_d  = bus.in_data;
        state_d = HALF;
      end else begin
        push    = 1'b1;
        state_d = EMPTY;
      end
    end
  end

  // FSM state and held first operand.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  bundle_pair_fifo #(
    .DEPTH (DEPTH),
    .T     (pair_w_t)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (fifo_count)
  );

  assign bus.out_in1 = head.in1;
  assign bus.out_in2 = head.in2;
  assign bus.count   = fifo_count;

endmodule

// File: tb/tb_bundle_pair_packer.sv
// Bench for bundle_pair_packer: directed vectors plus a random soak, checked by a scoreboard.
// Expected bundles are queued at stimulus time; a monitor pops and compares on each handshake.
// A cycle model also tracks expected in_ready/count/out_valid every cycle.
module tb_bundle_pair_packer;
  localparam int W     = 4;
  localparam int DEPTH = 2;

  logic clock;
  logic reset;

  bundle_pair_packer_if #(.W(W), .DEPTH(DEPTH)) bus ();

  bundle_pair_packer #(.W(W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];

  // model state
  bit         auto_sb = 0;
  bit         mhalf = 0;
  logic [3:0] mhold = '0;
  int         mcnt = 0;

  // monitor state
  bit         prev_stall = 0;
  logic [7:0] prev_head = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && bus.count != 0; i++) step();
    chk("drain_count", bus.count, 0);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  // Cycle model: checks flow-control outputs and predicts pushes for the coming edge.
  always @(negedge clock) begin
    bit exp_rdy, acc, pop_m, push_m;
    if (reset) begin
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_count", bus.count, 0);
      mhalf = 0;
      mcnt  = 0;
      sb.delete();
    end else begin
      exp_rdy = !bus.clear && (!mhalf || mcnt != DEPTH);
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("count", bus.count, mcnt);
      chk("out_valid", bus.out_valid, mcnt != 0);
      acc    = bus.in_valid && exp_rdy;
      pop_m  = (mcnt != 0) && bus.out_ready;
      push_m = 0;
      if (bus.clear) begin
        mhalf = 0;
      end else if (acc) begin
        if (!mhalf) begin
          mhold = bus.in_data;
          mhalf = 1;
        end else begin
          push_m = 1;
          mhalf  = 0;
          if (auto_sb) sb.push_back({mhold, bus.in_data});
        end
      end
      mcnt = mcnt + int'(push_m) - int'(pop_m);
    end
  end

  // Output monitor: compares each consumed bundle with the scoreboard and checks head stability.
  always @(negedge clock) begin
    logic [7:0] exp;
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && bus.out_valid)
        chk("head_stable", {bus.out_in1, bus.out_in2}, prev_head);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual=%0h,%0h required=none at %0t",
                   bus.out_in1, bus.out_in2, $time);
        end else begin
          exp = sb.pop_front();
          chk("out_in1", bus.out_in1, exp[7:4]);
          chk("out_in2", bus.out_in2, exp[3:0]);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_head  = {bus.out_in1, bus.out_in2};
    end
  end

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h9;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b0;

    // reset asserted mid-cycle with a beat offered
    #1 reset = 1'b1;
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_count", bus.count, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    #1 chk("in_ready_after_reset", bus.in_ready, 1);

    // basic pair
    bus.out_ready = 1'b1;
    sb.push_back(8'h35);
    beat(4'h3);
    beat(4'h5);
    bus.in_valid = 1'b0;
    chk("basic_out_valid", bus.out_valid, 1);
    chk("basic_in1", bus.out_in1, 4'h3);
    chk("basic_in2", bus.out_in2, 4'h5);
    step();
    chk("basic_out_valid_drop", bus.out_valid, 0);

    // full FIFO and stalled second beat
    bus.out_ready = 1'b0;
    sb.push_back(8'h12);
    sb.push_back(8'h34);
    sb.push_back(8'h56);
    beat(4'h1);
    beat(4'h2);
    beat(4'h3);
    beat(4'h4);
    bus.in_valid = 1'b0;
    chk("full_count", bus.count, 2);
    beat(4'h5);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h6;
    #1 chk("full_stall_rdy", bus.in_ready, 0);
    step();
    chk("full_stall_rdy2", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    #1;
    chk("full_rdy_back", bus.in_ready, 1);
    chk("full_count_after_pop", bus.count, 1);
    step();
    bus.in_valid = 1'b0;
    chk("full_count_refill", bus.count, 2);
    drain();

    // clear discards held beat and blocks the simultaneous one
    bus.out_ready = 1'b1;
    sb.push_back(8'hCD);
    beat(4'hA);
    bus.in_data = 4'hB;
    bus.clear   = 1'b1;
    #1 chk("clear_in_ready", bus.in_ready, 0);
    step();
    bus.clear = 1'b0;
    #1 chk("clear_then_rdy", bus.in_ready, 1);
    beat(4'hC);
    beat(4'hD);
    drain();

    // simultaneous push and pop with one bundle buffered
    bus.out_ready = 1'b0;
    sb.push_back(8'hEF);
    sb.push_back(8'h23);
    beat(4'hE);
    beat(4'hF);
    bus.in_valid = 1'b0;
    chk("sim_count_before", bus.count, 1);
    beat(4'h2);
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h3;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("sim_count_after", bus.count, 1);
    chk("sim_head_in1", bus.out_in1, 4'h2);
    chk("sim_head_in2", bus.out_in2, 4'h3);
    drain();

    // reset while a bundle is buffered and a first operand is held
    bus.out_ready = 1'b0;
    sb.push_back(8'h89);
    beat(4'h8);
    beat(4'h9);
    beat(4'h7);
    bus.in_data = 4'h1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_count", bus.count, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    step();
    step();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_rdy_after", bus.in_ready, 1);
    chk("midrst_count_after", bus.count, 0);
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk("midrst_sb_empty", sb.size(), 0);

    // random soak
    auto_sb = 1;
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.clear     = ($urandom_range(0, 31) == 0);
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bundle_pair_packer.md
# bundle_pair_packer

Front-end that drives a two-operand bundle (`out_in1`, `out_in2`) from a serial operand stream. Each pair of accepted input beats becomes one bundle: the first beat is `in1`, the second is `in2`. Completed bundles are buffered in a small FIFO and issued to a downstream consumer, such as an adder submodule, over a valid/ready handshake. The block sits between a narrow operand source and any module whose IO is an `{in1, in2}` bundle.

## Interface
Parameters:
- `W`, default 4: operand width.
- `DEPTH`, default 2: bundle FIFO entries. Must be ≥1 and a power of two.

Ports:
- `clock`, input, 1: sole clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: beat accepted when `in_valid && in_ready`.
- `in_data`, input, W: operand beat.
- `clear`, input, 1: synchronous; discards a half-assembled pair.
- `out_valid`, output, 1: FIFO head holds a bundle.
- `out_ready`, input, 1: consumer takes the head when `out_valid && out_ready`.
- `out_in1`, output, W: head bundle, first operand.
- `out_in2`, output, W: head bundle, second operand.
- `count`, output, $clog2(DEPTH+1): bundles currently buffered.

## Operation
FSM states:
- `EMPTY`: no operand held.
- `HALF`: `in1` held in `hold_q`.

Transitions:
- `EMPTY` + accepted beat: `hold_q <= in_data`, go to `HALF`.
- `HALF` + accepted beat: push `{hold_q, in_data}` into the FIFO, go to `EMPTY`.
- `HALF` + `clear`: go to `EMPTY`. `hold_q` is don't-care.
- `clear` in `EMPTY`: no effect.

`in_ready`:
- Low while `reset`=1.
- Low when `clear`=1. `clear` wins over a simultaneous beat, and that beat is not accepted.
- Otherwise high in `EMPTY`.
- Otherwise in `HALF`, equal to `count != DEPTH`.
- Registered state only; there is no combinational path from `out_ready` to `in_ready`.

FIFO behaviour:
- `out_valid = (count != 0)`.
- `out_in1`/`out_in2` come directly from the head entry. They are stable while `out_valid && !out_ready`.
- Push and pop in the same cycle: both occur, `count` unchanged, pointers advance.
- Pop when empty: impossible, since `out_valid`=0.
- Push when full: impossible, since `in_ready`=0 in `HALF`.
- Pointers wrap modulo `DEPTH`.
- `clear` never affects FIFO contents or `count`.

Data is passed through unmodified. No arithmetic is performed on the operands.

## Timing
Reset values, async, visible while `reset`=1:
- `out_valid`=0, `count`=0, `in_ready`=0.
- state=`EMPTY`, pointers=0.

After reset deasserts:
- `in_ready`=1 in the first cycle.

Latency:
- The second beat is accepted at edge N.
- `out_valid`=1 with that bundle in the cycle after edge N.
- Minimum in→out latency is 1 cycle after the pair completes.

Throughput:
- One bundle per two input cycles, sustained, when `out_ready`=1.

Backpressure:
- With the FIFO full, `EMPTY` still accepts a first beat.
- `HALF` stalls until a pop frees a slot. `in_ready` rises the cycle after the pop edge.

Reset mid-operation:
- A held `in1` and all buffered bundles are lost.
- Outputs go to reset values immediately.

## Structure
Package `bundle_pair_pkg`:
- `W_DEFAULT`=4.
- `state_e` enum: `EMPTY`, `HALF`.
- `pair_t` struct: `{logic [W-1:0] in1; logic [W-1:0] in2;}`.

Sub-module `bundle_pair_fifo`:
- Parameterised on `DEPTH` and `pair_t`.
- Owns storage, pointers, `count`, and the push/pop handshake.
- The top-level module holds only the FSM and `hold_q`.

## Test plan
- **Reset:** assert `reset` mid-cycle with `in_valid`=1. Required: `out_valid`=0, `count`=0, and `in_ready`=0 asynchronously. After deassert, `in_ready`=1.
- **Basic pair:** `out_ready`=1, beats 0x3 then 0x5 on consecutive cycles. Required: next cycle `out_valid`=1, `out_in1`=0x3, `out_in2`=0x5, then `out_valid` drops.
- **Full FIFO:** `out_ready`=0, beats 1,2,3,4,5,6.
  - After 4 beats: `count`=2.
  - Beat 5 is accepted and beat 6 stalls with `in_ready`=0.
  - Raise `out_ready` for one cycle: head (1,2) is popped, `in_ready` returns, and (5,6) is pushed.
  - Required final order: (3,4), then (5,6).
- **Clear:** beat 0xA accepted, then `clear`=1 with `in_valid`=1 and data 0xB. Required: 0xB not accepted. Then beats 0xC,0xD produce the bundle (0xC,0xD); 0xA never appears.
- **Simultaneous push/pop:** `count`=1, `out_ready`=1, second beat completes in the same cycle. Required: `count` stays 1, the old head is consumed, and the new bundle becomes head.
- **Random soak:** random `in_valid`/`out_ready` for 10k cycles against a scoreboard queue. Required: every pair emitted in order, no loss or duplication, and head stable while stalled.
